// File: rtl/debug_cmd_encoder_pkg.sv
// rtl/debug_cmd_encoder_pkg.sv - debug command encodings, CSR/opcode constants, sequence helpers
package debug_cmd_encoder_pkg;

  typedef enum logic [2:0] {
    CMD_REG_RD = 3'd0,
    CMD_REG_WR = 3'd1,
    CMD_CSR_RD = 3'd2,
    CMD_CSR_WR = 3'd3,
    CMD_MEM_RD = 3'd4
  } dbg_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } enc_state_t;

  localparam logic [6:0]  OP_SYSTEM     = 7'b1110011;
  localparam logic [6:0]  OP_LOAD       = 7'b0000011;
  localparam logic [11:0] CSR_DSCRATCH0 = 12'h7B2;
  localparam logic [11:0] CSR_DSCRATCH1 = 12'h7B3;
  localparam logic [2:0]  FUNCT3_CSRRW  = 3'b001;
  localparam logic [2:0]  FUNCT3_CSRRS  = 3'b010;
  localparam logic [2:0]  FUNCT3_LW     = 3'b010;

  function automatic logic cmd_is_defined(input dbg_cmd_t op);
    return (op == CMD_REG_RD) || (op == CMD_REG_WR) || (op == CMD_CSR_RD) ||
           (op == CMD_CSR_WR) || (op == CMD_MEM_RD);
  endfunction

  // Register accesses are a single instruction; everything else is save/op/move/restore.
  function automatic logic [1:0] cmd_last_step(input dbg_cmd_t op);
    return ((op == CMD_REG_RD) || (op == CMD_REG_WR)) ? 2'd0 : 2'd3;
  endfunction

endpackage

// File: rtl/debug_cmd_encoder_builder.sv
// rtl/debug_cmd_encoder_builder.sv - combinational I-type instruction word builder for debug sequences
module dbg_inst_builder
  import debug_cmd_encoder_pkg::*;
(
  input  dbg_cmd_t    op,
  input  logic [1:0]  step,
  input  logic [4:0]  regno,
  input  logic [11:0] csr,
  input  logic [4:0]  scratch,
  output logic [31:0] instr
);

  logic [11:0] imm;
  logic [4:0]  rs1;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [6:0]  opcode;

  always_comb begin
    imm    = 12'h000;
    rs1    = 5'd0;
    funct3 = 3'b000;
    rd     = 5'd0;
    opcode = 7'd0;
    case (op)
      CMD_REG_RD: begin
        opcode = OP_SYSTEM; funct3 = FUNCT3_CSRRW; imm = CSR_DSCRATCH0; rs1 = regno;
      end
      CMD_REG_WR: begin
        opcode = OP_SYSTEM; funct3 = FUNCT3_CSRRS; imm = CSR_DSCRATCH0; rd = regno;
      end
      CMD_CSR_RD, CMD_CSR_WR, CMD_MEM_RD: begin
        opcode = OP_SYSTEM;
        case (step)
          // Steps 0 and 3 swap the scratch GPR with data1 (save, then restore).
          2'd0, 2'd3: begin
            funct3 = FUNCT3_CSRRW; imm = CSR_DSCRATCH1; rs1 = scratch; rd = scratch;
          end
          2'd1: begin
            if (op == CMD_MEM_RD) begin
              opcode = OP_LOAD; funct3 = FUNCT3_LW; imm = 12'h000; rs1 = scratch; rd = scratch;
            end else if (op == CMD_CSR_RD) begin
              funct3 = FUNCT3_CSRRS; imm = csr; rd = scratch;
            end else begin
              funct3 = FUNCT3_CSRRS; imm = CSR_DSCRATCH0; rd = scratch;
            end
          end
          default: begin
            funct3 = FUNCT3_CSRRW; rs1 = scratch;
            imm = (op == CMD_CSR_WR) ? csr : CSR_DSCRATCH0;
          end
        endcase
      end
      default: opcode = 7'd0;
    endcase
  end

  assign instr = {imm, rs1, funct3, rd, opcode};

endmodule

// File: rtl/debug_cmd_encoder.sv
// rtl/debug_cmd_encoder.sv - debug command sequencer injecting encoded RV32I/Zicsr words into the core
module debug_cmd_encoder
  import debug_cmd_encoder_pkg::*;
#(
  parameter int SCRATCH_REG = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  dbg_cmd_t    cmd_op,
  input  logic [4:0]  cmd_regno,
  input  logic [11:0] cmd_csr,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        inj_valid,
  input  logic        inj_ready,
  output logic [31:0] inj_instr,
  input  logic        inj_retire,
  input  logic        inj_exc,
  input  logic        csr_we,
  input  logic        csr_sel,
  input  logic [31:0] csr_wdata,
  output logic [31:0] data0_q,
  output logic [31:0] data1_q,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  localparam logic [4:0] SCRATCH = 5'(SCRATCH_REG);

  enc_state_t  state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic        err_q, err_d;
  dbg_cmd_t    op_q;
  logic [4:0]  regno_q;
  logic [11:0] csr_q;
  logic [31:0] data0_d, data1_d;
  logic        inj_valid_d, rsp_valid_d;
  logic        accept, bad_cmd;
  dbg_cmd_t    bld_op;
  logic [4:0]  bld_regno;
  logic [11:0] bld_csr;
  logic [31:0] bld_instr;

  assign cmd_ready = (state_q == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign bad_cmd   = !cmd_is_defined(cmd_op) || (cmd_csr == CSR_DSCRATCH0) ||
                     (cmd_csr == CSR_DSCRATCH1);

  // The first word must be ready the cycle after accept, so build from the live command then.
  assign bld_op    = accept ? cmd_op    : op_q;
  assign bld_regno = accept ? cmd_regno : regno_q;
  assign bld_csr   = accept ? cmd_csr   : csr_q;

  dbg_inst_builder u_builder (
    .op      (bld_op),
    .step    (step_d),
    .regno   (bld_regno),
    .csr     (bld_csr),
    .scratch (SCRATCH),
    .instr   (bld_instr)
  );

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    err_d       = err_q;
    inj_valid_d = inj_valid;
    rsp_valid_d = rsp_valid;
    case (state_q)
      IDLE: begin
        if (accept) begin
          step_d = 2'd0;
          if (bad_cmd) begin
            err_d = 1'b1; state_d = RESP; rsp_valid_d = 1'b1;
          end else begin
            state_d = ISSUE; inj_valid_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (inj_ready) begin
          state_d = WAIT; inj_valid_d = 1'b0;
        end
      end
      WAIT: begin
        if (inj_exc) begin
          err_d = 1'b1;
          // A trap before the save needs no restore; a trapping restore cannot be retried.
          if ((step_q == 2'd0) || (step_q == 2'd3)) begin
            state_d = RESP; rsp_valid_d = 1'b1;
          end else begin
            step_d = 2'd3; state_d = ISSUE; inj_valid_d = 1'b1;
          end
        end else if (inj_retire) begin
          if (step_q == cmd_last_step(op_q)) begin
            state_d = RESP; rsp_valid_d = 1'b1;
          end else begin
            step_d = step_q + 2'd1; state_d = ISSUE; inj_valid_d = 1'b1;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE; rsp_valid_d = 1'b0; err_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Core writes apply except to a register the command is loading this cycle.
  always_comb begin
    data0_d = data0_q;
    data1_d = data1_q;
    if (csr_we && !csr_sel) data0_d = csr_wdata;
    if (csr_we && csr_sel)  data1_d = csr_wdata;
    if (accept) begin
      data0_d = cmd_data;
      if (cmd_op == CMD_MEM_RD) data1_d = cmd_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      step_q    <= 2'd0;
      err_q     <= 1'b0;
      op_q      <= CMD_REG_RD;
      regno_q   <= 5'd0;
      csr_q     <= 12'h000;
      data0_q   <= 32'd0;
      data1_q   <= 32'd0;
      inj_valid <= 1'b0;
      inj_instr <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      err_q     <= err_d;
      data0_q   <= data0_d;
      data1_q   <= data1_d;
      inj_valid <= inj_valid_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= (state_d == RESP) && err_d;
      if (accept) begin
        op_q    <= cmd_op;
        regno_q <= cmd_regno;
        csr_q   <= cmd_csr;
      end
      if (state_d == ISSUE) inj_instr <= bld_instr;
      if (state_d == RESP)  rsp_data  <= data0_d;
    end
  end

endmodule

// File: tb/tb_debug_cmd_encoder.sv
// tb/tb_debug_cmd_encoder.sv - randomized self-checking bench for debug_cmd_encoder
module tb_debug_cmd_encoder;
  import debug_cmd_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  dbg_cmd_t    cmd_op;
  logic [4:0]  cmd_regno;
  logic [11:0] cmd_csr;
  logic [31:0] cmd_addr, cmd_data;
  logic        inj_valid, inj_ready, inj_retire, inj_exc;
  logic [31:0] inj_instr;
  logic        csr_we, csr_sel;
  logic [31:0] csr_wdata, data0_q, data1_q;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_rsp_data, got_d0_hs, got_d1_hs, exp_rsp_data;
  logic        got_rsp_err, exp_err;
  int          got_lat;
  bit          got_timeout, got_stable;

  debug_cmd_encoder #(.SCRATCH_REG(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_regno(cmd_regno),
    .cmd_csr(cmd_csr), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .inj_valid(inj_valid), .inj_ready(inj_ready), .inj_instr(inj_instr),
    .inj_retire(inj_retire), .inj_exc(inj_exc),
    .csr_we(csr_we), .csr_sel(csr_sel), .csr_wdata(csr_wdata),
    .data0_q(data0_q), .data1_q(data1_q),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc(input longint imm, input longint rs1, input longint f3,
                                      input longint rd, input longint opc);
    longint v;
    v = imm * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + opc;
    return v[31:0];
  endfunction

  function automatic bit writes_d0(input logic [31:0] w);
    return (w[31:20] == 12'h7B2) && (w[14:12] == 3'b001) && (w[11:7] == 5'd0) && (w[6:0] == 7'h73);
  endfunction

  // Expected instruction stream, error and response data, straight from the command semantics.
  task automatic model_cmd(input int op, input int rn, input int csr, input logic [31:0] data,
                           input int exc_step, input logic [31:0] core_val);
    logic [31:0] seq[$];
    logic [31:0] swap, to_d0;
    int s;
    s = 8;
    swap  = enc(12'h7B3, s, 1, s, 115);
    to_d0 = enc(12'h7B2, s, 1, 0, 115);
    exp_q.delete();
    case (op)
      0: seq = '{enc(12'h7B2, rn, 1, 0, 115)};
      1: seq = '{enc(12'h7B2, 0, 2, rn, 115)};
      2: seq = '{swap, enc(csr, 0, 2, s, 115), to_d0, swap};
      3: seq = '{swap, enc(12'h7B2, 0, 2, s, 115), enc(csr, s, 1, 0, 115), swap};
      4: seq = '{swap, enc(0, s, 2, s, 3), to_d0, swap};
      default: seq.delete();
    endcase
    exp_err = (seq.size() == 0) || (csr == 12'h7B2) || (csr == 12'h7B3);
    exp_rsp_data = data;
    if (!exp_err) begin
      if (exc_step < 0 || exc_step >= seq.size()) begin
        exp_q = seq;
      end else begin
        exp_err = 1'b1;
        for (int i = 0; i <= exc_step; i++) exp_q.push_back(seq[i]);
        if (exc_step != 0 && exc_step != 3) exp_q.push_back(seq[3]);
      end
      for (int i = 0; i < exp_q.size(); i++)
        if (writes_d0(exp_q[i]) && i != exc_step) exp_rsp_data = core_val;
    end
  endtask

  // Acts as transport + core: issues the command, accepts injections, retires or traps them.
  task automatic run_cmd(input int op, input int rn, input int csr, input logic [31:0] addr,
                         input logic [31:0] data, input int exc_step, input int bp,
                         input logic [31:0] core_val);
    int cyc, budget;
    logic [31:0] first;
    got_q.delete();
    got_timeout = 1; got_stable = 1; got_lat = -1;
    got_d0_hs = 32'd0; got_d1_hs = 32'd0; got_rsp_data = 32'd0; got_rsp_err = 1'b0;
    cmd_valid = 1'b1; cmd_op = dbg_cmd_t'(op[2:0]); cmd_regno = rn[4:0];
    cmd_csr = csr[11:0]; cmd_addr = addr; cmd_data = data;
    budget = 0;
    while (!cmd_ready && budget < 50) begin @(posedge clk); #1; budget++; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cyc = 1;
    while (cyc < 300) begin
      if (rsp_valid) begin
        got_lat = cyc; got_rsp_data = rsp_data; got_rsp_err = rsp_err; got_timeout = 0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        break;
      end
      if (inj_valid) begin
        first = inj_instr;
        if (got_q.size() == 0) begin got_d0_hs = data0_q; got_d1_hs = data1_q; end
        for (int k = 0; k < bp; k++) begin
          @(posedge clk); #1; cyc++;
          if (inj_instr !== first || inj_valid !== 1'b1) got_stable = 0;
        end
        got_q.push_back(inj_instr);
        inj_ready = 1'b1;
        @(posedge clk); #1; cyc++;
        inj_ready = 1'b0;
        if (got_q.size() - 1 == exc_step) begin
          inj_exc = 1'b1;
        end else begin
          inj_retire = 1'b1;
          if (writes_d0(first)) begin csr_we = 1'b1; csr_sel = 1'b0; csr_wdata = core_val; end
        end
        @(posedge clk); #1; cyc++;
        inj_exc = 1'b0; inj_retire = 1'b0; csr_we = 1'b0;
      end else begin
        @(posedge clk); #1; cyc++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (cmd_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready); end
    tests_run++; if (inj_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_inj_valid: got %b expected 0", inj_valid); end
    tests_run++; if (inj_instr !== 32'd0) begin tests_failed++; $display("FAIL reset_inj_instr: got %h expected 0", inj_instr); end
    tests_run++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp: got valid %b err %b expected 0 0", rsp_valid, rsp_err); end
    tests_run++; if (rsp_data !== 32'd0) begin tests_failed++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
    tests_run++; if (data0_q !== 32'd0 || data1_q !== 32'd0) begin tests_failed++; $display("FAIL reset_data: got %h %h expected 0 0", data0_q, data1_q); end
    rst = 1'b0;
    #1;
    tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL post_reset_cmd_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_reg_rd();
    model_cmd(0, 5, 12'h300, 32'h0BAD0BAD, -1, 32'hDEADBEEF);
    run_cmd(0, 5, 12'h300, 32'd0, 32'h0BAD0BAD, -1, 0, 32'hDEADBEEF);
    tests_run++; if (got_timeout) begin tests_failed++; $display("FAIL reg_rd_timeout: got timeout expected response"); end
    tests_run++; if (got_q.size() != 1) begin tests_failed++; $display("FAIL reg_rd_count: got %0d expected 1", got_q.size()); end
    else begin tests_run++; if (got_q[0] !== 32'h7B229073) begin tests_failed++; $display("FAIL reg_rd_instr: got %h expected 7b229073", got_q[0]); end end
    tests_run++; if (got_rsp_data !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL reg_rd_data: got %h expected deadbeef", got_rsp_data); end
    tests_run++; if (got_rsp_err !== 1'b0) begin tests_failed++; $display("FAIL reg_rd_err: got %b expected 0", got_rsp_err); end
    tests_run++; if (got_lat != 3) begin tests_failed++; $display("FAIL reg_rd_latency: got %0d expected 3", got_lat); end
  endtask

  task automatic test_reg_wr();
    run_cmd(1, 5, 12'h300, 32'd0, 32'h12345678, -1, 0, 32'h0);
    tests_run++; if (got_q.size() != 1) begin tests_failed++; $display("FAIL reg_wr_count: got %0d expected 1", got_q.size()); end
    else begin tests_run++; if (got_q[0] !== 32'h7B2022F3) begin tests_failed++; $display("FAIL reg_wr_instr: got %h expected 7b2022f3", got_q[0]); end end
    tests_run++; if (got_d0_hs !== 32'h12345678) begin tests_failed++; $display("FAIL reg_wr_data0: got %h expected 12345678", got_d0_hs); end
    tests_run++; if (got_rsp_err !== 1'b0 || got_timeout) begin tests_failed++; $display("FAIL reg_wr_err: got err %b timeout %0d expected 0 0", got_rsp_err, got_timeout); end
  endtask

  task automatic test_mem_rd();
    logic [31:0] want[4];
    want = '{32'h7B341473, 32'h00042403, 32'h7B241073, 32'h7B341473};
    run_cmd(4, 0, 12'h000, 32'h80001000, 32'h0, -1, 0, 32'hCAFEF00D);
    tests_run++; if (got_q.size() != 4) begin tests_failed++; $display("FAIL mem_rd_count: got %0d expected 4", got_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      tests_run++; if (got_q[i] !== want[i]) begin tests_failed++; $display("FAIL mem_rd_instr%0d: got %h expected %h", i, got_q[i], want[i]); end
    end
    tests_run++; if (got_d1_hs !== 32'h80001000) begin tests_failed++; $display("FAIL mem_rd_data1: got %h expected 80001000", got_d1_hs); end
    tests_run++; if (got_rsp_data !== 32'hCAFEF00D) begin tests_failed++; $display("FAIL mem_rd_rsp: got %h expected cafef00d", got_rsp_data); end
  endtask

  task automatic test_csr_exc();
    logic [31:0] want[3];
    want = '{32'h7B341473, 32'h30002473, 32'h7B341473};
    run_cmd(2, 0, 12'h300, 32'h0, 32'h55AA55AA, 1, 0, 32'h0);
    tests_run++; if (got_q.size() != 3) begin tests_failed++; $display("FAIL csr_exc_count: got %0d expected 3", got_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      tests_run++; if (got_q[i] !== want[i]) begin tests_failed++; $display("FAIL csr_exc_instr%0d: got %h expected %h", i, got_q[i], want[i]); end
    end
    tests_run++; if (got_rsp_err !== 1'b1 || got_timeout) begin tests_failed++; $display("FAIL csr_exc_err: got err %b timeout %0d expected 1 0", got_rsp_err, got_timeout); end
  endtask

  task automatic test_bad_cmd();
    int ops[2];
    int csrs[2];
    ops = '{3, 6};
    csrs = '{12'h7B2, 12'h300};
    for (int i = 0; i < 2; i++) begin
      run_cmd(ops[i], 1, csrs[i], 32'h0, 32'h1, -1, 0, 32'h0);
      tests_run++; if (got_q.size() != 0) begin tests_failed++; $display("FAIL bad_cmd%0d_injected: got %0d instrs expected 0", i, got_q.size()); end
      tests_run++; if (got_rsp_err !== 1'b1 || got_timeout) begin tests_failed++; $display("FAIL bad_cmd%0d_err: got err %b timeout %0d expected 1 0", i, got_rsp_err, got_timeout); end
    end
  endtask

  task automatic test_backpressure();
    run_cmd(0, 7, 12'h300, 32'h0, 32'h0, -1, 5, 32'h11112222);
    tests_run++; if (got_stable !== 1'b1) begin tests_failed++; $display("FAIL backpressure_stable: got %0d expected 1", got_stable); end
    tests_run++; if (got_q.size() != 1 || got_q[0] !== enc(12'h7B2, 7, 1, 0, 115)) begin tests_failed++; $display("FAIL backpressure_instr: got %0d instrs expected one csrrw x0,0x7b2,x7", got_q.size()); end
  endtask

  task automatic test_csr_port();
    csr_we = 1'b1; csr_sel = 1'b1; csr_wdata = 32'hA5A5F00F;
    @(posedge clk); #1;
    csr_sel = 1'b0; csr_wdata = 32'h01234567;
    @(posedge clk); #1;
    csr_we = 1'b0;
    tests_run++; if (data1_q !== 32'hA5A5F00F) begin tests_failed++; $display("FAIL csr_port_data1: got %h expected a5a5f00f", data1_q); end
    tests_run++; if (data0_q !== 32'h01234567) begin tests_failed++; $display("FAIL csr_port_data0: got %h expected 01234567", data0_q); end
  endtask

  task automatic test_reset_mid();
    int budget, seen;
    cmd_valid = 1'b1; cmd_op = CMD_CSR_RD; cmd_regno = 5'd3; cmd_csr = 12'h341; cmd_data = 32'h77;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    budget = 0;
    while (!inj_valid && budget < 20) begin @(posedge clk); #1; budget++; end
    inj_ready = 1'b1;
    @(posedge clk); #1;
    inj_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (inj_valid !== 1'b0 || inj_instr !== 32'd0) begin tests_failed++; $display("FAIL mid_reset_inj: got valid %b instr %h expected 0 0", inj_valid, inj_instr); end
    tests_run++; if (rsp_valid !== 1'b0 || rsp_data !== 32'd0 || data0_q !== 32'd0) begin tests_failed++; $display("FAIL mid_reset_rsp: got valid %b data %h d0 %h expected zeros", rsp_valid, rsp_data, data0_q); end
    rst = 1'b0;
    #1;
    tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL mid_reset_cmd_ready: got %b expected 1", cmd_ready); end
    inj_retire = 1'b1;
    @(posedge clk); #1;
    inj_retire = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (inj_valid === 1'b1 || rsp_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    tests_run++; if (seen != 0) begin tests_failed++; $display("FAIL mid_reset_no_restore: got %0d active cycles expected 0", seen); end
  endtask

  task automatic test_random();
    int op, rn, csr, exc, bp, r;
    logic [31:0] addr, data, cv;
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 7);
      if ($urandom_range(0, 3) != 0) op = $urandom_range(0, 4);
      rn = $urandom_range(1, 31);
      r = $urandom_range(0, 11);
      csr = (r == 0) ? 12'h7B2 : (r == 1) ? 12'h7B3 : $urandom_range(0, 4095);
      r = $urandom_range(0, 7);
      exc = (r < 4) ? r : -1;
      bp = $urandom_range(0, 2);
      addr = $urandom; data = $urandom; cv = $urandom;
      model_cmd(op, rn, csr, data, exc, cv);
      run_cmd(op, rn, csr, addr, data, exc, bp, cv);
      tests_run++; if (got_timeout) begin tests_failed++; $display("FAIL rand%0d_timeout: got no response expected one", it); end
      tests_run++; if (got_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL rand%0d_count: got %0d expected %0d (op %0d exc %0d)", it, got_q.size(), exp_q.size(), op, exc); end
      else for (int i = 0; i < exp_q.size(); i++) begin
        tests_run++; if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL rand%0d_instr%0d: got %h expected %h", it, i, got_q[i], exp_q[i]); end
      end
      tests_run++; if (got_rsp_err !== exp_err) begin tests_failed++; $display("FAIL rand%0d_err: got %b expected %b", it, got_rsp_err, exp_err); end
      tests_run++; if (got_rsp_data !== exp_rsp_data) begin tests_failed++; $display("FAIL rand%0d_data: got %h expected %h", it, got_rsp_data, exp_rsp_data); end
      if (got_q.size() > 0) begin
        tests_run++; if (got_d0_hs !== data) begin tests_failed++; $display("FAIL rand%0d_data0_load: got %h expected %h", it, got_d0_hs, data); end
        if (op == 4) begin
          tests_run++; if (got_d1_hs !== addr) begin tests_failed++; $display("FAIL rand%0d_data1_load: got %h expected %h", it, got_d1_hs, addr); end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = CMD_REG_RD; cmd_regno = 5'd0; cmd_csr = 12'h0;
    cmd_addr = 32'd0; cmd_data = 32'd0; inj_ready = 1'b0; inj_retire = 1'b0; inj_exc = 1'b0;
    csr_we = 1'b0; csr_sel = 1'b0; csr_wdata = 32'd0; rsp_ready = 1'b0;
    test_reset();
    test_reg_rd();
    test_reg_wr();
    test_mem_rd();
    test_csr_exc();
    test_bad_cmd();
    test_backpressure();
    test_csr_port();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
